// File: rtl/apogeo_operations_pkg.sv
// ----------------------------------------------------------------------------
// apogeo_operations_pkg
// Shared definitions for the integer execution unit's division block:
//   div_uop_t   - division micro-op encoding (DIV, DIVU, REM, REMU)
//   div_state_t - control states of the iterative divider
//   uop_is_signed / uop_is_rem - operation decode helpers
// ----------------------------------------------------------------------------
package apogeo_operations_pkg;

  typedef enum logic [1:0] {
    UOP_DIV  = 2'b00,
    UOP_DIVU = 2'b01,
    UOP_REM  = 2'b10,
    UOP_REMU = 2'b11
  } div_uop_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  // Any encoding not listed decodes as DIVU: unsigned, quotient selected.
  function automatic logic uop_is_signed(input div_uop_t uop);
    case (uop)
      UOP_DIV, UOP_REM: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic uop_is_rem(input div_uop_t uop);
    case (uop)
      UOP_REM, UOP_REMU: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/div_iteration_step.sv
// ----------------------------------------------------------------------------
// div_iteration_step
// Combinational restoring-division slice resolving BITS_PER_CYCLE quotient
// bits, MSB first, by chaining shift/compare/subtract steps.
// Ports:
//   rem_i        - current partial remainder (DATA_WIDTH+1 bits)
//   shift_bits_i - next dividend bits to shift in, MSB first
//   divisor_i    - divisor magnitude
//   rem_o        - partial remainder after all steps
//   quot_bits_o  - resolved quotient bits, MSB first
// ----------------------------------------------------------------------------
module div_iteration_step #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [DATA_WIDTH:0]       rem_i,
  input  logic [BITS_PER_CYCLE-1:0] shift_bits_i,
  input  logic [DATA_WIDTH-1:0]     divisor_i,
  output logic [DATA_WIDTH:0]       rem_o,
  output logic [BITS_PER_CYCLE-1:0] quot_bits_o
);

  logic [DATA_WIDTH:0] chain [BITS_PER_CYCLE+1];

  assign chain[0] = rem_i;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    logic [DATA_WIDTH+1:0] shifted;
    logic [DATA_WIDTH:0]   diff;
    logic                  fits;

    // The shifted value keeps one extra bit so the compare is exact; the
    // difference itself always fits in DATA_WIDTH+1 bits when it is used.
    assign shifted = {chain[g], shift_bits_i[BITS_PER_CYCLE-1-g]};
    assign fits    = shifted >= {2'b00, divisor_i};
    assign diff    = shifted[DATA_WIDTH:0] - {1'b0, divisor_i};

    assign chain[g+1]                        = fits ? diff : shifted[DATA_WIDTH:0];
    assign quot_bits_o[BITS_PER_CYCLE-1-g]   = fits;
  end

  assign rem_o = chain[BITS_PER_CYCLE];

endmodule

// File: rtl/division_unit_iterative.sv
// ----------------------------------------------------------------------------
// division_unit_iterative
// Iterative RISC-V DIV/DIVU/REM/REMU unit, BITS_PER_CYCLE quotient bits per
// cycle, valid/ready on both sides, passthrough tag, flush, and a one-cycle
// early-out for divide-by-zero and signed overflow.
// Ports:
//   clk_i, rst_n_i      - clock, asynchronous active-low reset
//   clk_en_i            - clock enable; low freezes all state
//   flush_i             - kills the in-flight operation
//   valid_i / ready_o   - operand handshake
//   dividend_i, divisor_i, operation_i, tag_i - operation
//   result_o, divide_by_zero_o, tag_o         - registered result
//   valid_o / ready_i   - result handshake
//   idle_o              - no operation in flight (registered)
// ----------------------------------------------------------------------------
module division_unit_iterative
  import apogeo_operations_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_WIDTH      = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic [1:0]            operation_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  divide_by_zero_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  idle_o
);

  localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(N - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_t              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH:0]     prem_q;      // partial remainder
  logic [DATA_WIDTH-1:0]   quo_q;       // dividend bits out, quotient bits in
  logic [DATA_WIDTH-1:0]   divisor_q;
  logic                    neg_quot_q;
  logic                    neg_rem_q;
  logic                    want_rem_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    dbz_q;
  logic                    valid_q;
  logic                    idle_q;

  // Accept-side decode
  div_uop_t                uop;
  logic                    op_signed;
  logic                    op_rem;
  logic                    dvd_neg;
  logic                    dvs_neg;
  logic [DATA_WIDTH-1:0]   dvd_mag;
  logic [DATA_WIDTH-1:0]   dvs_mag;
  logic                    div_zero;
  logic                    overflow;
  logic [DATA_WIDTH-1:0]   special_result;
  logic                    accept;

  // Iteration and fix-up datapath
  logic [DATA_WIDTH:0]     step_rem;
  logic [BITS_PER_CYCLE-1:0] step_bits;
  logic [DATA_WIDTH-1:0]   rem_fixed;
  logic [DATA_WIDTH-1:0]   quot_fixed;
  logic [DATA_WIDTH-1:0]   fix_result;

  assign uop = div_uop_t'(operation_i);

  always_comb begin
    // NOTE: every signal of a combinational block is assigned on every path
    // (defaults first), otherwise synthesis infers a latch to hold it.
    op_signed      = uop_is_signed(uop);
    op_rem         = uop_is_rem(uop);
    dvd_neg        = op_signed & dividend_i[DATA_WIDTH-1];
    dvs_neg        = op_signed & divisor_i[DATA_WIDTH-1];
    dvd_mag        = dvd_neg ? -dividend_i : dividend_i;
    dvs_mag        = dvs_neg ? -divisor_i  : divisor_i;
    div_zero       = (divisor_i == '0);
    overflow       = op_signed & (dividend_i == MOST_NEG) & (divisor_i == '1);
    special_result = '0;
    if (div_zero) begin
      special_result = op_rem ? dividend_i : '1;
    end else if (!op_rem) begin
      special_result = dividend_i;
    end
  end

  // Combinational from ready_i so a drained result can be replaced in the
  // same cycle; a flush always blocks acceptance.
  assign ready_o = ~flush_i & ((state_q == IDLE) | ((state_q == DONE) & ready_i));
  assign accept  = valid_i & ready_o & clk_en_i;

  div_iteration_step #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .rem_i       (prem_q),
    .shift_bits_i(quo_q[DATA_WIDTH-1 -: BITS_PER_CYCLE]),
    .divisor_i   (divisor_q),
    .rem_o       (step_rem),
    .quot_bits_o (step_bits)
  );

  // Remainder follows the dividend's sign, quotient is negative when the
  // operand signs differ; a zero remainder stays zero.
  always_comb begin
    rem_fixed  = prem_q[DATA_WIDTH-1:0];
    if (neg_rem_q && (prem_q[DATA_WIDTH-1:0] != '0)) begin
      rem_fixed = -prem_q[DATA_WIDTH-1:0];
    end
    quot_fixed = neg_quot_q ? -quo_q : quo_q;
    fix_result = want_rem_q ? rem_fixed : quot_fixed;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples values from before the clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the datapath registers are reset too, because they drive the
      // result/tag outputs directly and those must read zero out of reset.
      state_q    <= IDLE;
      cnt_q      <= '0;
      prem_q     <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_rem_q <= 1'b0;
      tag_q      <= '0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
      valid_q    <= 1'b0;
      idle_q     <= 1'b1;
    end else if (clk_en_i) begin
      if (flush_i) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        idle_q  <= 1'b1;
      end else if (accept) begin
        // Reached from IDLE, or from DONE while the result is being taken.
        tag_q  <= tag_i;
        idle_q <= 1'b0;
        if (div_zero || overflow) begin
          result_q <= special_result;
          dbz_q    <= div_zero;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end else begin
          prem_q     <= '0;
          quo_q      <= dvd_mag;
          divisor_q  <= dvs_mag;
          neg_quot_q <= dvd_neg ^ dvs_neg;
          neg_rem_q  <= dvd_neg;
          want_rem_q <= op_rem;
          cnt_q      <= '0;
          valid_q    <= 1'b0;
          state_q    <= ITER;
        end
      end else begin
        case (state_q)
          ITER: begin
            prem_q <= step_rem;
            quo_q  <= (quo_q << BITS_PER_CYCLE) | DATA_WIDTH'(step_bits);
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_q <= FIX;
            end
          end
          FIX: begin
            result_q <= fix_result;
            dbz_q    <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
          DONE: begin
            if (ready_i) begin
              valid_q <= 1'b0;
              idle_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign result_o         = result_q;
  assign divide_by_zero_o = dbz_q;
  assign tag_o            = tag_q;
  assign valid_o          = valid_q;
  assign idle_o           = idle_q;

endmodule
